// File: rtl/idrob_queue.sv
// ---------------------------------------------------------------------------
// idrob_queue
//
// In-order FIFO of packed decode bundles sitting between ID and ROB. It lets
// ID keep decoding while ROB is stalled. Flow control is valid/ready on both
// sides. A flush drops every queued bundle. An almost-full hint lets ID stall
// early, before the queue is completely full.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous, active-low reset
//   flush        in   discard all entries (mispredict / exception recovery)
//   push_valid   in   ID offers push_data
//   push_ready   out  queue accepts a bundle this cycle
//   push_data    in   DATA_WIDTH bundle from ID
//   pop_valid    out  head bundle is presented to ROB
//   pop_ready    in   ROB consumes the head bundle
//   pop_data     out  head bundle, all zeros when nothing is presented
//   count        out  occupancy, 0..DEPTH
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AFULL_THRESH
// ---------------------------------------------------------------------------
module idrob_queue #(
    parameter int DATA_WIDTH   = 256,
    parameter int DEPTH        = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_AFULL = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q,    cnt_d;

    logic push_fire;
    logic pop_fire;

    // Status flags decode registered state only, so they move after an edge.
    // Ready does not look at pop_ready: a full queue refuses pushes for the
    // whole cycle, even when a pop fires in that same cycle.
    assign full        = (cnt_q == CNT_DEPTH);
    assign empty       = (cnt_q == '0);
    assign almost_full = (cnt_q >= CNT_AFULL);
    assign count       = cnt_q;

    assign push_ready = rst & ~full;
    assign pop_valid  = rst & ~empty;
    assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;

    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;

    // Pointer and occupancy next state. Flush overrides any handshake fired
    // in the same cycle. Pointers wrap through natural ADDR_WIDTH overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    cnt_d    = cnt_q + CNT_ONE;
                end
                2'b01: begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    cnt_d    = cnt_q - CNT_ONE;
                end
                2'b11: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset: contents are only visible through pop_valid.
    // push_fire already includes rst, so nothing is written during reset.
    always_ff @(posedge clk) begin
        if (push_fire && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_idrob_queue.sv
module tb_idrob_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int AFT   = 3;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          pushValid;
   logic          pushReady;
   logic [DW-1:0] pushData;
   logic          popValid;
   logic          popReady;
   logic [DW-1:0] popData;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almostFull;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] modelQ[$];
   bit            modelValid = 0;

   idrob_queue #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .ADDR_WIDTH(AW),
      .AFULL_THRESH(AFT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .push_valid(pushValid),
      .push_ready(pushReady),
      .push_data(pushData),
      .pop_valid(popValid),
      .pop_ready(popReady),
      .pop_data(popData),
      .count(count),
      .full(full),
      .empty(empty),
      .almost_full(almostFull)
   );

   // free-running clock, 10 time units per cycle
   initial clk = 0;
   always #5 clk = ~clk;

   // one comparison: bumps the counters and reports a mismatch
   task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // drive one cycle's worth of inputs just after the rising edge
   task automatic applyStimulus(input logic r, input logic fl, input logic pv, input logic [DW-1:0] pd, input logic pr);
      @(posedge clk);
      #1;
      rst       = r;
      flush     = fl;
      pushValid = pv;
      pushData  = pd;
      popReady  = pr;
   endtask

   // reference model: an ordered list of stored bundles, updated per edge
   always @(posedge clk) begin
      bit doPush;
      bit doPop;
      doPush = rst && pushValid && (modelQ.size() < DEPTH);
      doPop  = rst && popReady && (modelQ.size() > 0);
      if (!rst || flush) begin
         modelQ.delete();
      end else begin
         if (doPop) void'(modelQ.pop_front());
         if (doPush) modelQ.push_back(pushData);
      end
      if (!rst) modelValid = 1;
   end

   // every cycle once the model is known, compare all outputs mid-cycle
   always @(negedge clk) begin
      if (modelValid) begin
         int sz;
         logic expPopValid;
         sz = modelQ.size();
         expPopValid = rst && (sz > 0);
         checkOutput("push_ready", {31'b0, pushReady}, {31'b0, rst && (sz < DEPTH)});
         checkOutput("pop_valid", {31'b0, popValid}, {31'b0, expPopValid});
         checkOutput("pop_data", popData, expPopValid ? modelQ[0] : 32'h0);
         checkOutput("count", {29'b0, count}, sz);
         checkOutput("full", {31'b0, full}, {31'b0, sz == DEPTH});
         checkOutput("empty", {31'b0, empty}, {31'b0, sz == 0});
         checkOutput("almost_full", {31'b0, almostFull}, {31'b0, sz >= AFT});
      end
   end

   initial begin
      rst       = 0;
      flush     = 0;
      pushValid = 0;
      pushData  = 0;
      popReady  = 0;

      // reset held for two edges
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rst_push_ready", {31'b0, pushReady}, 32'h0);
      checkOutput("rst_empty", {31'b0, empty}, 32'h1);
      checkOutput("rst_count", {29'b0, count}, 32'h0);
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rel_push_ready", {31'b0, pushReady}, 32'h1);
      checkOutput("rel_pop_data", popData, 32'h0);

      // fill with four bundles, ROB stalled
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 1, 32'hbfc00000 + 32'(4 * i), 0);
         @(negedge clk);
         checkOutput("fill_count", {29'b0, count}, 32'(i));
         if (i == 3) checkOutput("fill_afull3", {31'b0, almostFull}, 32'h1);
      end
      // hold a fifth bundle for two cycles: must be refused
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 1, 32'hbfc00010, 0);
         @(negedge clk);
         checkOutput("full_flag", {31'b0, full}, 32'h1);
         checkOutput("full_count", {29'b0, count}, 32'h4);
         checkOutput("full_push_ready", {31'b0, pushReady}, 32'h0);
      end
      // drain in order
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 0, 0, 1);
         @(negedge clk);
         checkOutput("drain_data", popData, 32'hbfc00000 + 32'(4 * i));
      end
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("drain_empty", {31'b0, empty}, 32'h1);
      checkOutput("drain_pop_data", popData, 32'h0);

      // one-cycle latency through an empty queue
      applyStimulus(1, 0, 1, 32'h12345678, 0);
      @(negedge clk);
      checkOutput("lat_valid_n", {31'b0, popValid}, 32'h0);
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("lat_valid_n1", {31'b0, popValid}, 32'h1);
      checkOutput("lat_data_n1", popData, 32'h12345678);
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0);

      // steady push+pop at count 2, pointers wrap repeatedly
      applyStimulus(1, 0, 1, 32'h100, 0);
      applyStimulus(1, 0, 1, 32'h101, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 0, 1, 32'h102 + 32'(i), 1);
         @(negedge clk);
         checkOutput("stream_count", {29'b0, count}, 32'h2);
         checkOutput("stream_head", popData, 32'h100 + 32'(i));
      end
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0);

      // full plus pop: push refused that cycle, accepted the next
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 32'h200 + 32'(i), 0);
      applyStimulus(1, 0, 1, 32'h2ff, 1);
      @(negedge clk);
      checkOutput("fp_ready", {31'b0, pushReady}, 32'h0);
      applyStimulus(1, 0, 1, 32'h2ff, 0);
      @(negedge clk);
      checkOutput("fp_count3", {29'b0, count}, 32'h3);
      checkOutput("fp_ready_back", {31'b0, pushReady}, 32'h1);
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("fp_count4", {29'b0, count}, 32'h4);

      // flush at count 3 together with push and pop
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 1, 1, 32'habcdef00, 1);
      @(negedge clk);
      checkOutput("fl_pre_count", {29'b0, count}, 32'h3);
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("fl_count", {29'b0, count}, 32'h0);
      checkOutput("fl_empty", {31'b0, empty}, 32'h1);
      checkOutput("fl_pop_data", popData, 32'h0);
      checkOutput("fl_ready", {31'b0, pushReady}, 32'h1);

      // reset in the middle of operation at count 2
      applyStimulus(1, 0, 1, 32'h300, 0);
      applyStimulus(1, 0, 1, 32'h301, 0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 1, 32'h3ff, 0);
         @(negedge clk);
         checkOutput("mr_ready", {31'b0, pushReady}, 32'h0);
      end
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("mr_count", {29'b0, count}, 32'h0);
      checkOutput("mr_empty", {31'b0, empty}, 32'h1);
      applyStimulus(1, 0, 1, 32'h400, 0);
      applyStimulus(1, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("mr_after_data", popData, 32'h400);

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 99) != 0),
                       ($urandom_range(0, 49) == 0),
                       ($urandom_range(0, 9) < 7),
                       $urandom,
                       ($urandom_range(0, 1) == 1));
      end
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idrob_queue.md
# idrob_queue

Parametrised decoded-instruction queue between the ID stage and the ROB stage. It replaces the single-entry ID→ROB pipeline register with a DEPTH-entry in-order FIFO of packed decode bundles, so ID can keep decoding while ROB is busy. It uses valid/ready handshakes, a flush for mispredict and exception recovery, occupancy reporting and an almost-full early-stall hint for ID. Entries leave in exactly the order they enter.

## Interface
Parameters:
- DATA_WIDTH, default 256: width of one packed decode bundle (reg write, branch, mem, CP0, exception, funct/shamt, operands, pc).
- DEPTH, default 4: number of entries; power of two, ≥2.
- ADDR_WIDTH, default 2: log2(DEPTH).
- AFULL_THRESH, default 3: occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discard all entries.
- push_valid  in  1  ID offers push_data.
- push_ready  out  1  queue accepts this cycle.
- push_data  in  DATA_WIDTH  bundle from ID.
- pop_valid  out  1  head entry is presented.
- pop_ready  in  1  ROB consumes the head.
- pop_data  out  DATA_WIDTH  head bundle; all zeros when empty.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.

## Operation
- Storage and state:
  - DEPTH×DATA_WIDTH register array.
  - Write pointer wr_ptr and read pointer rd_ptr, each ADDR_WIDTH bits.
  - Occupancy counter cnt, ADDR_WIDTH+1 bits.
- Handshakes:
  - push fires = push_valid & push_ready.
  - pop fires = pop_valid & pop_ready.
- Output decode:
  - push_ready = rst & !full. It does not depend on pop_ready, so there is no combinational ready path.
  - pop_valid = rst & !empty.
  - pop_data = array[rd_ptr] when pop_valid, else 0.
- Update priority on each rising edge, highest first:
  1. rst low: wr_ptr, rd_ptr and cnt go to 0. Array contents are don't-care.
  2. flush high: wr_ptr, rd_ptr and cnt go to 0. A push or pop fired in the same cycle is discarded.
  3. push only: write array[wr_ptr], wr_ptr+1, cnt+1.
  4. pop only: rd_ptr+1, cnt−1.
  5. push and pop together: write and advance both pointers; cnt unchanged.
- Pointers wrap modulo DEPTH through natural ADDR_WIDTH-bit overflow.
- cnt never exceeds DEPTH and never goes below 0; the handshake gating guarantees this.
- push_valid while full is ignored and the data is not stored; ID must hold the bundle.
- pop_ready while empty has no effect.
- Both handshake flags are flow-control only; neither carries a separate per-entry valid bit.
- Reset value of every output while rst is low and on the first cycle after release:
  - push_ready 0 while rst low, 1 after release.
  - pop_valid 0, pop_data 0.
  - count 0, full 0, empty 1, almost_full 0.

## Timing
- Latency: a bundle pushed at edge N appears on pop_data and pop_valid after edge N, i.e. in cycle N+1. There is no combinational push-to-pop bypass; an empty queue always adds one cycle.
- Throughput: one push and one pop per cycle sustained for any 1 ≤ count ≤ DEPTH−1.
- Backpressure:
  - With full, push_ready is 0 for the whole cycle, even if pop fires in that cycle.
  - push_ready returns to 1 in the cycle after the pop edge.
- Status outputs: count, full, empty and almost_full are registered-state decodes and change only after a clock edge.
- Flush: takes effect at the edge where it is sampled high. The next cycle shows empty=1, pop_valid=0, pop_data=0 and push_ready=1. Flushing an already empty queue is harmless.
- Reset mid-operation: same effect as flush, and additionally push_ready=0 for as long as rst is low.

## Test plan
- Fill/drain (DEPTH=4, DATA_WIDTH=32, AFULL_THRESH=3):
  - Push 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c on consecutive cycles with pop_ready=0 → after the 3rd edge almost_full=1; after the 4th edge full=1, count=4, push_ready=0.
  - Keep push_valid=1 with 0xbfc00010 for 2 cycles → not stored.
  - Then pop_ready=1 → pop_data 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c in order, then empty=1, pop_data=0.
- Latency: push 0x12345678 into an empty queue at edge N → pop_valid=0 in cycle N, pop_valid=1 with pop_data=0x12345678 in cycle N+1.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing data → count stays 2, no loss or reorder, pointers wrap at least twice.
- Full plus pop: count=4, pop_ready=1, push_valid=1 → the push is refused that cycle, count=3 next cycle, push accepted the cycle after.
- Flush: flush=1 together with push_valid=1 (0xabcdef00) and pop_ready=1 at count=3 → next cycle count=0, empty=1, pop_data=0; 0xabcdef00 is never popped.
- Reset mid-operation: rst=0 for 2 cycles at count=2 → push_ready=0 during reset; after release count=0, empty=1, and a subsequent push/pop sequence behaves normally.
